// File: rtl/glitch_pkg.sv
// ============================================================================
// glitch_pkg: shared state encoding, reset defaults and helpers for the
// glitch burst generator.   Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned RST_START = 16353;
  localparam int unsigned RST_LEN   = 2;

  // Saturating increment of a w-bit value carried in a 32-bit container.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/glitch_cfg_shadow.sv
// ============================================================================
// glitch_cfg_shadow: shadow configuration registers with load qualification,
// zero-to-one clamping and (GLITCH_SWEEP_EN) start sweep offset. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module glitch_cfg_shadow #(
  parameter int          CNT_W     = 16,
  parameter int          LEN_W     = 4,
  parameter int          PULSE_W   = 3,
  parameter int unsigned RST_START = glitch_pkg::RST_START,
  parameter int unsigned RST_LEN   = glitch_pkg::RST_LEN
`ifdef GLITCH_SWEEP_EN
  ,
  parameter int unsigned SWEEP_STEP = 1,
  parameter int unsigned SWEEP_SPAN = 16
`endif
) (
  input  logic               clk_96m,
  input  logic               rst_n,
  input  logic               idle_i,
  input  logic               glitch_i,
  input  logic               cfg_load_i,
  input  logic [CNT_W-1:0]   cfg_start_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic [LEN_W-1:0]   cfg_gap_i,
  input  logic [PULSE_W-1:0] cfg_pulses_i,
`ifdef GLITCH_SWEEP_EN
  input  logic               sweep_adv_i,
`endif
  output logic [CNT_W-1:0]   start_o,
  output logic [LEN_W-1:0]   len_o,
  output logic [LEN_W-1:0]   gap_o,
  output logic [PULSE_W-1:0] pulses_o
);
  import glitch_pkg::*;

  logic [CNT_W-1:0]   start_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   gap_q;
  logic [PULSE_W-1:0] pulses_q;
  logic               w_load;
  logic [CNT_W-1:0]   w_start_c;

  assign w_load = cfg_load_i && idle_i && !glitch_i;

  always_ff @(posedge clk_96m) begin
    if (!rst_n) begin
      start_q  <= CNT_W'(RST_START);
      len_q    <= LEN_W'(RST_LEN);
      gap_q    <= LEN_W'(1);
      pulses_q <= PULSE_W'(1);
    end else if (w_load) begin
      start_q  <= cfg_start_i;
      len_q    <= cfg_len_i;
      gap_q    <= cfg_gap_i;
      pulses_q <= cfg_pulses_i;
    end
  end

  assign w_start_c = (start_q == '0) ? CNT_W'(1) : start_q;
  assign len_o     = (len_q == '0) ? LEN_W'(1) : len_q;
  assign gap_o     = (gap_q == '0) ? LEN_W'(1) : gap_q;
  assign pulses_o  = (pulses_q == '0) ? PULSE_W'(1) : pulses_q;

`ifdef GLITCH_SWEEP_EN
  logic [CNT_W-1:0] offset_q;
  logic [CNT_W-1:0] offset_d;
  logic [CNT_W:0]   w_sum;

  always_comb begin
    offset_d = offset_q;
    if (w_load) begin
      offset_d = '0;
    end else if (sweep_adv_i) begin
      offset_d = ((32'(offset_q) + SWEEP_STEP) >= SWEEP_SPAN) ? '0
                                                               : (offset_q + CNT_W'(SWEEP_STEP));
    end
  end

  always_ff @(posedge clk_96m) begin
    if (!rst_n) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  // Offset is added after clamping so a zero start still sweeps from 1.
  assign w_sum   = {1'b0, w_start_c} + {1'b0, offset_q};
  assign start_o = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
`else
  assign start_o = w_start_c;
`endif

endmodule

`default_nettype wire

// File: rtl/glitch_burst_gen.sv
// ============================================================================
// glitch_burst_gen: delayed, repeatable open-drain CPU reset pulse burst.
// Optional start sweep: GLITCH_SWEEP_EN.   Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module glitch_burst_gen #(
  parameter int          CNT_W     = 16,
  parameter int          LEN_W     = 4,
  parameter int          PULSE_W   = 3,
  parameter int          ATT_W     = 8,
  parameter int unsigned RST_START = glitch_pkg::RST_START,
  parameter int unsigned RST_LEN   = glitch_pkg::RST_LEN
`ifdef GLITCH_SWEEP_EN
  ,
  parameter int unsigned SWEEP_STEP = 1,
  parameter int unsigned SWEEP_SPAN = 16
`endif
) (
  input  logic               clk_96m,
  input  logic               rst_n,
  input  logic               glitch,
  input  logic               cfg_load,
  input  logic [CNT_W-1:0]   cfg_start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [LEN_W-1:0]   cfg_gap,
  input  logic [PULSE_W-1:0] cfg_pulses,
  inout  wire                cpu_reset,
  output logic               busy,
  output logic               done,
  output logic [ATT_W-1:0]   attempt_cnt
);
  import glitch_pkg::*;

  state_e             state_q;
  logic [CNT_W-1:0]   tick_q;
  logic [LEN_W-1:0]   seg_q;
  logic [PULSE_W-1:0] idx_q;
  logic               drive_low_q;
  logic               busy_q;
  logic               done_q;
  logic [ATT_W-1:0]   att_q;

  logic [CNT_W-1:0]   w_start;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_gap;
  logic [PULSE_W-1:0] w_pulses;
  logic               w_more;

  glitch_cfg_shadow #(
    .CNT_W     (CNT_W),
    .LEN_W     (LEN_W),
    .PULSE_W   (PULSE_W),
    .RST_START (RST_START),
    .RST_LEN   (RST_LEN)
`ifdef GLITCH_SWEEP_EN
    ,
    .SWEEP_STEP(SWEEP_STEP),
    .SWEEP_SPAN(SWEEP_SPAN)
`endif
  ) u_cfg (
    .clk_96m     (clk_96m),
    .rst_n       (rst_n),
    .idle_i      (state_q == ST_IDLE),
    .glitch_i    (glitch),
    .cfg_load_i  (cfg_load),
    .cfg_start_i (cfg_start),
    .cfg_len_i   (cfg_len),
    .cfg_gap_i   (cfg_gap),
    .cfg_pulses_i(cfg_pulses),
`ifdef GLITCH_SWEEP_EN
    .sweep_adv_i (state_q == ST_DONE && !glitch),
`endif
    .start_o     (w_start),
    .len_o       (w_len),
    .gap_o       (w_gap),
    .pulses_o    (w_pulses)
  );

  // Another pulse follows when idx+1 < pulses; widened to avoid wrap.
  assign w_more = ({1'b0, idx_q} + {{PULSE_W{1'b0}}, 1'b1}) < {1'b0, w_pulses};

  always_ff @(posedge clk_96m) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      seg_q       <= '0;
      idx_q       <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      att_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (glitch) begin
            state_q <= ST_WAIT;
            tick_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT, ST_PULSE, ST_GAP: begin
          if (!glitch) begin
            state_q     <= ST_IDLE;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            seg_q       <= '0;
          end else if (state_q == ST_WAIT) begin
            if (tick_q == (w_start - CNT_W'(1))) begin
              state_q     <= ST_PULSE;
              drive_low_q <= 1'b1;
              seg_q       <= '0;
            end else begin
              tick_q <= tick_q + CNT_W'(1);
            end
          end else if (state_q == ST_PULSE) begin
            if (seg_q == (w_len - LEN_W'(1))) begin
              drive_low_q <= 1'b0;
              seg_q       <= '0;
              if (w_more) begin
                state_q <= ST_GAP;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                att_q   <= ATT_W'(sat_inc(32'(att_q), ATT_W));
              end
            end else begin
              seg_q <= seg_q + LEN_W'(1);
            end
          end else begin
            if (seg_q == (w_gap - LEN_W'(1))) begin
              state_q     <= ST_PULSE;
              drive_low_q <= 1'b1;
              seg_q       <= '0;
              idx_q       <= idx_q + PULSE_W'(1);
            end else begin
              seg_q <= seg_q + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (!glitch) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          drive_low_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset   = drive_low_q ? 1'b0 : 1'bz;
  assign busy        = busy_q;
  assign done        = done_q;
  assign attempt_cnt = att_q;

endmodule

`default_nettype wire
